md_ctrl: RTL
============

Name: md_ctrl

Overview:
- Sequencing controller for the multiply/divide unit in the EX stage of the 5-stage pipeline.
- Accepts one mult/multu/div/divu/mthi/mtlo issue per cycle from EX and models a multi-cycle latency.
- Owns the HI/LO architectural registers.
- Produces the busy/stall signal that the hazard unit ORs into the pipeline stall for ID-stage multiply/divide-class instructions.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  EX-stage instruction is an md-class op this cycle
op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved (no-op)
a  input  32  rs operand (forwarded value)
b  input  32  rt operand (forwarded value)
id_md  input  1  ID-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
busy  output  1  long operation in flight
hi  output  32  HI register
lo  output  32  LO register
md_stall  output  1  combinational: id_md && (busy || (start && op<=3))

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, counter 0, busy 0, hi 0, lo 0. Effective immediately, including mid-operation. In-flight result discarded; HI/LO not updated.
- FSM states: IDLE, RUN.
- IDLE, start && op in {0..3} at edge k:
  - Latch op, a, b; counter <= N-1, with N = MULT_CYCLES for op<=1, DIV_CYCLES otherwise.
  - Go to RUN. busy high for cycles k+1 .. k+N inclusive.
- RUN:
  - Counter decrements each edge.
  - At the edge where the counter is 0: write HI/LO with the computed result, go to IDLE, deassert busy.
  - New value visible on hi/lo in the same cycle busy is first low.
  - An mfhi/mflo issued that cycle reads the new value.
- Arithmetic, results computed from latched operands (may be computed combinationally and held; only the commit time is architectural):
  - mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0].
  - multu: unsigned 32x32 -> 64.
  - div: LO = quotient truncated toward zero, HI = remainder with sign of dividend. -2^31 / -1 gives LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (b==0, div or divu): operation runs the full DIV_CYCLES, then HI/LO retain their previous values.
- mthi/mtlo, start && op in {4,5} while IDLE: hi<=a or lo<=a at the next edge, single cycle, busy stays 0.
- Reserved ops 6-7: no state change.
- start while RUN: ignored, no state change. This is a protocol violation, because md_stall prevents it. The bench flags it as an error.
- Simultaneous start and commit: the commit edge is in RUN, so any start on that edge is ignored. Issue is legal only in IDLE.
- md_stall:
  - Covers the cycle an op is being started.
  - The next md-class instruction in ID is held until busy drops.
  - Stall ends in the first cycle busy is low. That instruction then enters EX in IDLE.
- The hazard unit is not modified internally; it consumes md_stall.

Test Plan:
- mult a=0xFFFFFFFF, b=0x00000002 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE in the first cycle busy=0.
- multu, same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 -> lo=3, hi=1.
- Edge divides:
  - div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - div with b=0, after prior hi=0x11, lo=0x22 -> 10 busy cycles, then hi=0x11, lo=0x22 unchanged.
- mtlo a=0x12345678 in IDLE -> lo=0x12345678 next edge, busy never asserted.
- Stall and reset interaction:
  - id_md=1 during the start cycle and all 5 busy cycles of a mult -> md_stall=1 for 6 cycles, 0 when busy falls.
  - reset_n pulsed low mid-div (cycle 4) -> busy, hi, lo = 0 immediately. No commit afterwards.

Source files
------------

// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer with multi-cycle latency, HI/LO ownership and ID-stage stall.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        id_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [31:0] cnt;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [63:0] prod_s, prod_u, div_s, div_u, res;
    logic [31:0] abs_a, abs_b, q_mag, r_mag, q_u, r_u;
    logic        div_zero, commit, issue_long;
    assign issue_long = start && !op[2];
    always_comb begin
        state_nx = state;
        if (state == IDLE && issue_long)
            state_nx = RUN;
        else if (state == RUN && cnt == 32'd0)
            state_nx = IDLE;
    end
    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    // Signed divide via magnitudes so that -2^31 / -1 wraps to 0x80000000 without overflow.
    assign abs_a    = a_q[31] ? -a_q : a_q;
    assign abs_b    = b_q[31] ? -b_q : b_q;
    assign div_zero = (b_q == 32'd0);
    assign q_mag    = div_zero ? 32'd0 : abs_a / abs_b;
    assign r_mag    = div_zero ? 32'd0 : abs_a % abs_b;
    assign q_u      = div_zero ? 32'd0 : a_q / b_q;
    assign r_u      = div_zero ? 32'd0 : a_q % b_q;
    assign div_s    = {a_q[31] ? -r_mag : r_mag, (a_q[31] ^ b_q[31]) ? -q_mag : q_mag};
    assign div_u    = {r_u, q_u};
    assign res      = op_q == 2'd0 ? prod_s : op_q == 2'd1 ? prod_u : op_q == 2'd2 ? div_s : div_u;
    // Divide by zero still occupies the unit for the full latency but leaves HI/LO alone.
    assign commit   = state == RUN && cnt == 32'd0 && !(op_q[1] && div_zero);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 32'd0;
            op_q  <= 2'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                if (!op[2]) begin
                    op_q <= op[1:0];
                    a_q  <= a;
                    b_q  <= b;
                    cnt  <= op[1] ? 32'(DIV_CYCLES - 1) : 32'(MULT_CYCLES - 1);
                end else if (op == 3'd4) begin
                    hi <= a;
                end else if (op == 3'd5) begin
                    lo <= a;
                end
            end else if (state == RUN) begin
                cnt <= cnt - 32'd1;
                if (commit) begin
                    hi <= res[63:32];
                    lo <= res[31:0];
                end
            end
        end
    end
    assign busy     = (state == RUN);
    assign md_stall = id_md && (busy || issue_long);
endmodule
